audio_codec_if_master: RTL

- Codec-side (clock-master) end of the WM8731 serial audio link used by the record/play path.
- Generates BCLK and LRCLK, serialises a stereo sample pair onto SDOUT (drives the ADCDAT input of the sample consumer), and deserialises SDIN (driven from the DACDAT output of the sample producer) into a stereo pair.
- Used to run the codec in slave mode and as a synthesizable loopback fixture for the record/play path.

---
 rtl/audio_if_pkg.sv | 20 ++
 rtl/audio_bclk_gen.sv | 96 +++++++++
 rtl/audio_codec_if_master.sv | 129 ++++++++++++
 3 files changed

// File: rtl/audio_if_pkg.sv
// Shared constants and types for the WM8731 clock-master serial link.
// Build option: AUDIO_LEFT_JUST_EN selects left-justified framing
// (data starts at slot position 0); otherwise I2S framing (one delay bit).
package audio_if_pkg;

    localparam int WORD_BITS_DEF = 16;
    localparam int SLOT_BITS_DEF = 32;

`ifdef AUDIO_LEFT_JUST_EN
    localparam int DATA_START = 0;
`else
    localparam int DATA_START = 1;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/audio_bclk_gen.sv
// Bit-clock divider, run/idle control and frame bit index for the serial link.
// Strobes are combinational and refer to the register update at the end of
// the current clk_50m cycle (rise/fall = BCLK is about to change).
module audio_bclk_gen
    import audio_if_pkg::*;
#(
    parameter int  BCLK_DIV  = 16,
    parameter int  SLOT_BITS = SLOT_BITS_DEF,
    localparam int DW        = $clog2(BCLK_DIV),
    localparam int BW        = $clog2(2 * SLOT_BITS)
) (
    input  logic          clk_50m,
    input  logic          reset_n,
    input  logic          enable,
    output logic          bclk,
    output logic          lrclk,
    output logic [BW-1:0] b,
    output logic [BW-1:0] b_nxt,
    output logic          rise,
    output logic          fall,
    output logic          frame_start,
    output logic          frame_end
);

    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
    localparam logic [BW-1:0] B_LAST   = BW'(2 * SLOT_BITS - 1);
    localparam logic [BW-1:0] SLOT_B   = BW'(SLOT_BITS);

    state_t        state, state_nxt;
    logic [DW-1:0] div_cnt, div_nxt;
    logic          bclk_nxt, lrclk_nxt;

    // State, divider, bit index and clock outputs
    always_ff @(posedge clk_50m or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            div_cnt <= '0;
            b       <= '0;
            bclk    <= 1'b0;
            lrclk   <= 1'b0;
        end else begin
            state   <= state_nxt;
            div_cnt <= div_nxt;
            b       <= b_nxt;
            bclk    <= bclk_nxt;
            lrclk   <= lrclk_nxt;
        end
    end

    // Next state: enable only matters in IDLE and at the frame wrap, so a
    // running frame always completes
    always_comb begin
        state_nxt   = state;
        div_nxt     = div_cnt;
        b_nxt       = b;
        bclk_nxt    = bclk;
        rise        = 1'b0;
        fall        = 1'b0;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt   = RUN;
                    div_nxt     = '0;
                    b_nxt       = '0;
                    frame_start = 1'b1;
                end
            end
            RUN: begin
                if (div_cnt == DIV_LAST) begin
                    div_nxt  = '0;
                    bclk_nxt = ~bclk;
                    if (!bclk) begin
                        rise = 1'b1;
                    end else begin
                        fall = 1'b1;
                        if (b == B_LAST) begin
                            frame_end = 1'b1;
                            b_nxt     = '0;
                            if (enable) frame_start = 1'b1;
                            else        state_nxt   = IDLE;
                        end else begin
                            b_nxt = b + 1'b1;
                        end
                    end
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        lrclk_nxt = (state_nxt == RUN) && (b_nxt >= SLOT_B);
    end

endmodule

// File: rtl/audio_codec_if_master.sv
// Clock-master end of the WM8731 serial audio link: generates BCLK/LRCLK,
// serialises a latched stereo pair onto SDOUT and deserialises SDIN.
// Build option: AUDIO_LEFT_JUST_EN selects left-justified framing instead of I2S.
module audio_codec_if_master
    import audio_if_pkg::*;
#(
    parameter int BCLK_DIV  = 16,
    parameter int WORD_BITS = WORD_BITS_DEF,
    parameter int SLOT_BITS = SLOT_BITS_DEF
) (
    input  logic                 clk_50m,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [WORD_BITS-1:0] tx_left,
    input  logic [WORD_BITS-1:0] tx_right,
    input  logic                 tx_valid,
    output logic                 tx_load,
    output logic                 tx_underrun,
    output logic [WORD_BITS-1:0] rx_left,
    output logic [WORD_BITS-1:0] rx_right,
    output logic                 rx_valid,
    output logic                 BCLK,
    output logic                 LRCLK,
    output logic                 SDOUT,
    input  logic                 SDIN
);

    localparam int BW = $clog2(2 * SLOT_BITS);
    localparam int IW = $clog2(WORD_BITS);
    localparam logic [BW-1:0] SLOT_B  = BW'(SLOT_BITS);
    localparam logic [BW-1:0] D_FIRST = BW'(DATA_START);
    localparam logic [BW-1:0] D_END   = BW'(DATA_START + WORD_BITS);
    localparam logic [BW-1:0] D_LSB   = BW'(DATA_START + WORD_BITS - 1);

    logic [BW-1:0]        b, b_nxt;
    logic                 rise, fall, frame_start, frame_end;
    logic [WORD_BITS-1:0] tx_l_q, tx_r_q, tx_word;
    logic [WORD_BITS-1:0] rx_sh_l, rx_sh_r;
    logic [BW-1:0]        p_n, p_c;
    logic [IW-1:0]        tx_idx;
    logic                 lr_n, lr_c, tx_bit, rx_pos, rx_last;

    audio_bclk_gen #(
        .BCLK_DIV  (BCLK_DIV),
        .SLOT_BITS (SLOT_BITS)
    ) u_bclk_gen (
        .clk_50m     (clk_50m),
        .reset_n     (reset_n),
        .enable      (enable),
        .bclk        (BCLK),
        .lrclk       (LRCLK),
        .b           (b),
        .b_nxt       (b_nxt),
        .rise        (rise),
        .fall        (fall),
        .frame_start (frame_start),
        .frame_end   (frame_end)
    );

    // Transmit bit for the slot position being entered; at a frame start the
    // fresh samples are used directly since the holding registers load now
    always_comb begin
        lr_n    = (b_nxt >= SLOT_B);
        p_n     = lr_n ? (b_nxt - SLOT_B) : b_nxt;
        tx_word = lr_n ? tx_r_q : tx_l_q;
        if (frame_start) tx_word = tx_valid ? (lr_n ? tx_right : tx_left) : '0;
        tx_idx  = IW'(WORD_BITS - 1) - IW'(p_n - D_FIRST);
        tx_bit  = 1'b0;
        if (p_n >= D_FIRST && p_n < D_END) tx_bit = tx_word[tx_idx];
    end

    // Receive position decode for the bit currently on the wire
    always_comb begin
        lr_c    = (b >= SLOT_B);
        p_c     = lr_c ? (b - SLOT_B) : b;
        rx_pos  = (p_c >= D_FIRST) && (p_c < D_END);
        rx_last = lr_c && (p_c == D_LSB);
    end

    // Frame-start sample latch and handshake pulses
    always_ff @(posedge clk_50m or negedge reset_n) begin
        if (!reset_n) begin
            tx_l_q      <= '0;
            tx_r_q      <= '0;
            tx_load     <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            tx_load     <= frame_start & tx_valid;
            tx_underrun <= frame_start & ~tx_valid;
            if (frame_start) begin
                tx_l_q <= tx_valid ? tx_left  : '0;
                tx_r_q <= tx_valid ? tx_right : '0;
            end
        end
    end

    // SDOUT changes together with the BCLK falling edge; forced low on stop
    always_ff @(posedge clk_50m or negedge reset_n) begin
        if (!reset_n) begin
            SDOUT <= 1'b0;
        end else if (frame_end && !frame_start) begin
            SDOUT <= 1'b0;
        end else if (frame_start || fall) begin
            SDOUT <= tx_bit;
        end
    end

    // MSB-first receive shift on BCLK rise; publish pair after right LSB
    always_ff @(posedge clk_50m or negedge reset_n) begin
        if (!reset_n) begin
            rx_sh_l  <= '0;
            rx_sh_r  <= '0;
            rx_left  <= '0;
            rx_right <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= rise & rx_last;
            if (rise && rx_pos) begin
                if (lr_c) rx_sh_r <= {rx_sh_r[WORD_BITS-2:0], SDIN};
                else      rx_sh_l <= {rx_sh_l[WORD_BITS-2:0], SDIN};
            end
            if (rise && rx_last) begin
                rx_left  <= rx_sh_l;
                rx_right <= {rx_sh_r[WORD_BITS-2:0], SDIN};
            end
        end
    end

endmodule
